// File: rtl/morse_player_pkg.sv
// Shared types and constants for the Morse player sequencer.
// Opcode and state encodings plus the unit multipliers used to size
// the on/off periods.
package morse_pkg;

  typedef enum logic [1:0] {
    OP_SPC = 2'b00,
    OP_DAH = 2'b01,
    OP_DIT = 2'b10,
    OP_END = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EMIT,
    GAP
  } state_e;

  localparam int DIT_UNITS = 1;
  localparam int DAH_UNITS = 3;
  localparam int SPC_UNITS = 1;

  // Length of a period in clock cycles, computed wide so 3*DIT_CYCLES never overflows
  function automatic longint unsigned unit_ticks(input int units, input int dit_cycles);
    return longint'(units) * longint'(dit_cycles);
  endfunction

endpackage

// File: rtl/morse_player_if.sv
// Host-side bundle of the Morse player: program write port, playback
// control and status. The host/config block is the master.
interface morse_player_if #(
  parameter int AW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic          emitter;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop,
    input  emitter, busy, done, pc
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop,
    output emitter, busy, done, pc
  );
endinterface

// File: rtl/morse_player_unit_timer.sv
// Loadable down-counter timing the on/off periods of the player.
// expire is high while the count sits at zero; the counter never wraps.
module morse_unit_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] value,
  output logic          expire
);

  logic [TW-1:0] count;

  // Clear beats load, load beats counting down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/morse_player.sv
// Morse player: runtime-loaded program of 2-bit opcodes played out on
// the emitter key with unit-timed on/off periods.
// Optional feature macro: MORSE_PLAYER_GAP_EN inserts one unit of
// silence after every DIT/DAH before moving to the next symbol.
module morse_player
  import morse_pkg::*;
#(
  parameter int DIT_CYCLES = 50000000,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  morse_player_if.slave bus
);

  localparam longint unsigned DAH_TICKS = unit_ticks(DAH_UNITS, DIT_CYCLES);
  localparam int TW = $clog2(DAH_TICKS);
  localparam logic [TW-1:0] DIT_LOAD = TW'(unit_ticks(DIT_UNITS, DIT_CYCLES) - 1);
  localparam logic [TW-1:0] DAH_LOAD = TW'(DAH_TICKS - 1);
  localparam logic [TW-1:0] SPC_LOAD = TW'(unit_ticks(SPC_UNITS, DIT_CYCLES) - 1);
`ifdef MORSE_PLAYER_GAP_EN
  localparam logic [TW-1:0] GAP_LOAD = TW'(unit_ticks(DIT_UNITS, DIT_CYCLES) - 1);
`endif
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    mem [DEPTH];
  state_e        state;
  op_e           op;
  logic [AW-1:0] pc;
  logic          emitter_q;
  logic          busy_q;
  logic          done_q;
  logic          produced;

  logic          timer_clear;
  logic          timer_load;
  logic          timer_en;
  logic [TW-1:0] timer_value;
  logic          timer_expire;
  logic          gap_next;
  logic          step_done;
  logic          at_end;

  // Program memory: writes are accepted in every state and are not reset
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Timer control and end-of-symbol / end-of-program detection
  always_comb begin
    timer_clear = bus.stop && (state != IDLE);
    timer_en    = (state == EMIT) || (state == GAP);
    timer_load  = 1'b0;
    timer_value = DIT_LOAD;
    gap_next    = 1'b0;
`ifdef MORSE_PLAYER_GAP_EN
    gap_next    = (state == EMIT) && timer_expire && (op != OP_SPC);
`endif
    if ((state == DECODE) && (op != OP_END)) begin
      timer_load = 1'b1;
      case (op)
        OP_DAH:  timer_value = DAH_LOAD;
        OP_SPC:  timer_value = SPC_LOAD;
        default: timer_value = DIT_LOAD;
      endcase
    end
`ifdef MORSE_PLAYER_GAP_EN
    if (gap_next) begin
      timer_load  = 1'b1;
      timer_value = GAP_LOAD;
    end
`endif
    step_done = ((state == EMIT) && timer_expire && !gap_next) ||
                ((state == GAP) && timer_expire);
    at_end    = ((state == DECODE) && (op == OP_END)) ||
                (step_done && (pc == LAST_ADDR));
  end

  morse_unit_timer #(
    .TW(TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .load   (timer_load),
    .en     (timer_en),
    .value  (timer_value),
    .expire (timer_expire)
  );

  // Playback sequencer: stop aborts from any state, program end loops or completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_SPC;
      pc        <= '0;
      emitter_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      produced  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state     <= IDLE;
        pc        <= '0;
        emitter_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (at_end) begin
        emitter_q <= 1'b0;
        pc        <= '0;
        if (bus.loop && produced) begin
          state <= FETCH;
        end else begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              pc       <= '0;
              produced <= 1'b0;
              busy_q   <= 1'b1;
              state    <= FETCH;
            end
          end
          FETCH: begin
            op        <= op_e'(mem[pc]);
            emitter_q <= 1'b0;
            state     <= DECODE;
          end
          DECODE: begin
            emitter_q <= (op != OP_SPC);
            produced  <= 1'b1;
            state     <= EMIT;
          end
          EMIT: begin
            if (timer_expire) begin
              emitter_q <= 1'b0;
              if (gap_next) begin
                state <= GAP;
              end else begin
                pc    <= pc + AW'(1);
                state <= FETCH;
              end
            end
          end
          GAP: begin
            if (timer_expire) begin
              pc    <= pc + AW'(1);
              state <= FETCH;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.emitter = emitter_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pc      = pc;

endmodule

// File: tb/tb_morse_player.sv
// Self-checking bench for morse_player (DIT_CYCLES=4, DEPTH=8).
// A symbol-level timeline model predicts emitter/busy/done/pc per cycle.
module tb_morse_player;

  localparam int DIT  = 4;
  localparam int DEP  = 8;
  localparam int MAXC = 200;
`ifdef MORSE_PLAYER_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  morse_player_if #(.AW(3)) bus ();

  morse_player #(
    .DIT_CYCLES (DIT),
    .DEPTH      (DEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  int   test_id    = 0;
  logic [1:0] prog [DEP];
  int   exp_em   [MAXC];
  int   exp_busy [MAXC];
  int   exp_done [MAXC];
  int   exp_pc   [MAXC];

  task automatic check_output(input string tag, input int obs, input int expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic write_program();
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = prog[i];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic mark(input int t, input int len, input int em, input int addr);
    for (int k = t; k < t + len; k++) begin
      if (k < MAXC) begin
        exp_em[k]   = em;
        exp_busy[k] = 1;
        exp_pc[k]   = addr;
      end
    end
  endtask

  // Timeline: start sampled at end of cycle 0; every symbol costs
  // 2 silent cycles, then 1 or 3 units, plus a unit gap when enabled
  task automatic build_model(input bit lp, input int stop_at);
    int t, addr, len;
    bit produced, finished, at_end;
    for (int k = 0; k < MAXC; k++) begin
      exp_em[k] = 0; exp_busy[k] = 0; exp_done[k] = 0; exp_pc[k] = 0;
    end
    t = 1; addr = 0; produced = 0; finished = 0;
    while (!finished && t < MAXC) begin
      mark(t, 2, 0, addr);
      t += 2;
      at_end = 0;
      if (prog[addr] == 2'b11) begin
        at_end = 1;
      end else begin
        len = (prog[addr] == 2'b01) ? 3 * DIT : DIT;
        mark(t, len, (prog[addr] == 2'b00) ? 0 : 1, addr);
        t += len;
        produced = 1;
        if (GAP_ON && prog[addr] != 2'b00) begin
          mark(t, DIT, 0, addr);
          t += DIT;
        end
        if (addr == DEP - 1) at_end = 1;
        else addr++;
      end
      if (at_end) begin
        addr = 0;
        if (!(lp && produced)) begin
          if (t < MAXC) exp_done[t] = 1;
          finished = 1;
        end
      end
    end
    if (stop_at > 0) begin
      for (int k = stop_at + 1; k < MAXC; k++) begin
        exp_em[k] = 0; exp_busy[k] = 0; exp_done[k] = 0; exp_pc[k] = 0;
      end
    end
  endtask

  task automatic check_cycle(input int c);
    check_output($sformatf("t%0d c%0d emitter", test_id, c), int'(bus.emitter), exp_em[c]);
    check_output($sformatf("t%0d c%0d busy", test_id, c), int'(bus.busy), exp_busy[c]);
    check_output($sformatf("t%0d c%0d done", test_id, c), int'(bus.done), exp_done[c]);
    check_output($sformatf("t%0d c%0d pc", test_id, c), int'(bus.pc), exp_pc[c]);
  endtask

  // Play the loaded program for n cycles with optional stop and ignored start
  task automatic apply_stimulus(input int n, input bit lp, input int stop_at, input int extra_start);
    test_id++;
    build_model(lp, stop_at);
    @(negedge clk);
    bus.loop = lp;
    check_cycle(0);
    bus.start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check_cycle(c);
      if (c == stop_at) bus.stop = 1'b1;
      if (c == extra_start && exp_busy[c] == 1 && c != stop_at) bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.stop  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset emitter", int'(bus.emitter), 0);
    check_output("reset busy", int'(bus.busy), 0);
    check_output("reset done", int'(bus.done), 0);
    check_output("reset pc", int'(bus.pc), 0);
    rst = 1'b0;

    // DIT, SPC, DAH, END
    prog = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    write_program();
    apply_stimulus(34, 1'b0, 0, 0);

    // DIT, END looping, stop while emitter is high
    prog = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    write_program();
    apply_stimulus(24, 1'b1, 20, 0);

    // END at address 0 with loop set completes once
    prog = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    write_program();
    apply_stimulus(8, 1'b1, 0, 0);

    // All DITs, no END: pc wraps, one done
    prog = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    write_program();
    apply_stimulus(8 * (2 + DIT + (GAP_ON ? DIT : 0)) + 4, 1'b0, 0, 20);

    // DIT, DIT, END (spacing depends on gap feature)
    prog = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    write_program();
    apply_stimulus(30, 1'b0, 0, 0);

    // start together with stop while idle stays idle
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check_output("start+stop busy", int'(bus.busy), 0);
    @(negedge clk);
    check_output("start+stop busy later", int'(bus.busy), 0);
    check_output("start+stop emitter", int'(bus.emitter), 0);

    // Reset in the middle of a DAH, then replay from address 0
    prog = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    write_program();
    bus.loop = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    check_output("mid-DAH emitter", int'(bus.emitter), 1);
    #2 rst = 1'b1;
    #1;
    check_output("async rst emitter", int'(bus.emitter), 0);
    check_output("async rst busy", int'(bus.busy), 0);
    check_output("async rst pc", int'(bus.pc), 0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(40, 1'b0, 0, 0);

    // Randomised programs, loop modes, aborts and ignored starts
    for (int it = 0; it < 20; it++) begin
      bit lp;
      int sa;
      for (int i = 0; i < DEP; i++) prog[i] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) prog[0] = 2'b11;
      lp = 1'($urandom_range(0, 1));
      sa = (lp || $urandom_range(0, 2) == 0) ? int'($urandom_range(10, 130)) : 0;
      write_program();
      apply_stimulus(140, lp, sa, int'($urandom_range(2, 100)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_player.md
Name: morse_player

Overview:
- Sequencer for the Morse emitter datapath.
- Holds a writable program of 2-bit symbol opcodes and plays it on command, keying `emitter` with unit-timed on/off periods.
- Provides start/stop control, loop mode and status back to a host/config block.
- Replaces a statically initialised program with a runtime-loaded one.

Parameters:
- DIT_CYCLES, 50000000: clock cycles per Morse unit (500 ms at 100 MHz); must be >= 1.
- DEPTH, 256: program memory entries; power of two, >= 2.
- AW, $clog2(DEPTH): address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  program write strobe
- wr_addr  in  AW  program write address
- wr_data  in  2  opcode written (00 SPC, 01 DAH, 10 DIT, 11 END)
- start  in  1  single-cycle pulse: begin playback at address 0
- stop  in  1  single-cycle pulse: abort playback
- loop  in  1  level; sampled at each program end; 1 = restart at address 0
- emitter  out  1  keying output
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on normal (non-aborted) completion
- pc  out  AW  address of the symbol currently being fetched or emitted

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, emitter=0, busy=0, done=0, timer=0. Program memory contents are not reset.
- Memory:
  - DEPTH x 2 bits; synchronous write on wr_en, accepted in every state.
  - A write to an address not yet fetched takes effect in the current playback.
- FSM states: IDLE, FETCH, DECODE, EMIT.
- IDLE:
  - start=1 and stop=0 -> pc=0, go to FETCH.
  - stop wins over a simultaneous start.
  - start while not IDLE is ignored.
- FETCH (1 cycle): op register <= mem[pc]; emitter=0.
- DECODE (1 cycle), by op:
  - DIT: timer loaded with 1*DIT_CYCLES-1, emitter<=1, go to EMIT.
  - DAH: timer loaded with 3*DIT_CYCLES-1, emitter<=1, go to EMIT.
  - SPC: timer loaded with 1*DIT_CYCLES-1, emitter stays 0, go to EMIT.
  - END: program end (see below).
- EMIT:
  - Timer decrements each cycle; emitter is held.
  - At timer==0: emitter<=0.
    - pc==DEPTH-1 -> program end.
    - Otherwise pc<=pc+1, go to FETCH.
- Program end:
  - loop=1 and the program produced at least one symbol -> pc<=0, go to FETCH.
  - Otherwise -> IDLE, pc<=0, done=1 for one cycle.
  - END at address 0 therefore always completes once (no zero-length infinite loop).
  - Without END, pc wraps at DEPTH-1 as above.
- Timing:
  - A DIT/DAH drives emitter high for exactly 1 or 3 units.
  - Each symbol carries 2 cycles of emitter low overhead (FETCH+DECODE) before it.
  - start to first emitter rise: 3 cycles.
- stop in FETCH/DECODE/EMIT: next cycle state=IDLE, emitter=0, pc=0, timer=0, done not asserted.
- Timer width: $clog2(3*DIT_CYCLES). The 3*DIT_CYCLES product is computed at a width that cannot overflow.

Optional Feature:
- MORSE_PLAYER_GAP_EN defined:
  - After every DIT or DAH, the FSM enters a GAP state for 1 unit (emitter=0) before advancing pc.
  - Standard inter-element spacing then needs no explicit SPC.
- Undefined: no GAP state; spacing comes only from SPC opcodes.

Decomposition:
- Package morse_pkg:
  - op_e enum logic [1:0]: OP_SPC=2'b00, OP_DAH=2'b01, OP_DIT=2'b10, OP_END=2'b11.
  - state_e enum: IDLE, FETCH, DECODE, EMIT, GAP.
  - Unit multipliers: DIT_UNITS=1, DAH_UNITS=3, SPC_UNITS=1.
- Sub-module morse_unit_timer: loadable down-counter with load/value inputs and expire output. Used by EMIT and GAP.

Test Plan (DIT_CYCLES=4, DEPTH=8, macro undefined unless noted):
- Program DIT,SPC,DAH,END; pulse start at cycle 0:
  - emitter high cycles 3-6, low 7-14, high 15-26.
  - done pulse at cycle 29; busy low from 29.
- Program DIT,END with loop=1; start:
  - emitter high 4 cycles every 8.
  - Pulse stop while emitter high -> emitter=0 and busy=0 next cycle, no done.
- END at address 0, loop=1; start -> busy high for 2 cycles, single done pulse, emitter never rises.
- All 8 entries DIT (no END), loop=0 -> exactly 8 emitter pulses, pc wraps to 0, one done.
- Assert rst mid-DAH -> emitter, busy, pc immediately 0. A subsequent start replays from address 0.
- start and stop in the same cycle while IDLE -> remains IDLE.
- With MORSE_PLAYER_GAP_EN, program DIT,DIT,END -> high 4, low 6, high 4.
